// File: rtl/error_link_rx.sv
// Receive end of the one-wire framed error link: start, WIDTH data bits LSB first, even parity,
// stop. Optional stale-neighbour timeout is compiled in with `define ERROR_LINK_STALE_EN.
module error_link_rx #(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned BIT_CYCLES   = 16,
  parameter int unsigned STALE_CYCLES = 4096
) (
  input  logic             fpga_clk_i,
  input  logic             reset_i,
  input  logic             enable_i,
  input  logic             serial_i,
  output logic [WIDTH-1:0] error_o,
  output logic             valid_o,
  output logic             parity_err_o,
  output logic             frame_err_o,
  output logic             stale_o
);

  localparam int unsigned CntW = $clog2(BIT_CYCLES);
  localparam int unsigned BitW = $clog2(WIDTH);
  localparam logic [CntW-1:0] HalfLast = CntW'(BIT_CYCLES / 2 - 1);
  localparam logic [CntW-1:0] FullLast = CntW'(BIT_CYCLES - 1);
  localparam logic [BitW-1:0] LastBit  = BitW'(WIDTH - 1);

  typedef enum logic [2:0] {
    StIdle, StStart, StData, StParity, StStop, StDecide, StBreak
  } state_e;

  state_e            state_q, state_d;
  logic              sync1_q, sync2_q;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [BitW-1:0]   bit_q, bit_d;
  logic [WIDTH-1:0]  shift_q, shift_d;
  logic              par_q, par_d;
  logic              stop_q, stop_d;
  logic [WIDTH-1:0]  error_q, error_d;
  logic              valid_q, valid_d;
  logic              perr_q, perr_d;
  logic              ferr_q, ferr_d;
  logic              start_edge, tick, par_ok;

  // sync2 is about to go 1->0 on this edge.
  assign start_edge = sync2_q && !sync1_q;
  assign tick       = (cnt_q == ((state_q == StStart) ? HalfLast : FullLast));
  assign par_ok     = ((^shift_q) == par_q);

`ifdef ERROR_LINK_STALE_EN
  localparam int unsigned StaleW = $clog2(STALE_CYCLES + 1);
  localparam logic [StaleW-1:0] StaleMax = StaleW'(STALE_CYCLES);
  localparam logic [StaleW-1:0] StaleHit = StaleW'(STALE_CYCLES - 1);

  logic [StaleW-1:0] stale_cnt_q, stale_cnt_d;
  logic              stale_q, stale_d, stale_hit;

  assign stale_hit = (stale_cnt_q == StaleHit);

  always_comb begin
    stale_cnt_d = stale_cnt_q;
    if (valid_d) begin
      stale_cnt_d = '0;
    end else if (stale_cnt_q != StaleMax) begin
      stale_cnt_d = stale_cnt_q + 1'b1;
    end
    stale_d = valid_d ? 1'b0 : (stale_q | stale_hit);
  end

  always_ff @(posedge fpga_clk_i or negedge reset_i) begin
    if (!reset_i) begin
      stale_cnt_q <= '0;
      stale_q     <= 1'b0;
    end else begin
      stale_cnt_q <= stale_cnt_d;
      stale_q     <= stale_d;
    end
  end

  assign stale_o = stale_q;
`else
  assign stale_o = 1'b0;
`endif

  always_ff @(posedge fpga_clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (start_edge) state_d = StStart;
      StStart:  if (tick) state_d = sync2_q ? StIdle : StData;
      StData:   if (tick && (bit_q == LastBit)) state_d = StParity;
      StParity: if (tick) state_d = StStop;
      StStop:   if (tick) state_d = StDecide;
      StDecide: state_d = stop_q ? StIdle : StBreak;
      StBreak:  if (sync2_q) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
    if (!enable_i) state_d = StIdle;
  end

  always_comb begin
    cnt_d   = cnt_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    stop_d  = stop_q;
    valid_d = 1'b0;
    perr_d  = 1'b0;
    ferr_d  = 1'b0;
    if (tick || (state_q == StIdle) || (state_q == StDecide) || (state_q == StBreak)) begin
      cnt_d = '0;
    end
    unique case (state_q)
      StIdle, StStart: bit_d = '0;
      StData: begin
        if (tick) begin
          shift_d = {sync2_q, shift_q[WIDTH-1:1]};
          bit_d   = bit_q + 1'b1;
        end
      end
      StParity: if (tick) par_d = sync2_q;
      StStop:   if (tick) stop_d = sync2_q;
      StDecide: begin
        valid_d = stop_q && par_ok;
        perr_d  = !par_ok;
        ferr_d  = !stop_q;
      end
      default: ;
    endcase
    if (!enable_i) begin
      cnt_d   = '0;
      bit_d   = '0;
      valid_d = 1'b0;
      perr_d  = 1'b0;
      ferr_d  = 1'b0;
    end
    error_d = error_q;
    if (valid_d) begin
      error_d = shift_q;
    end
`ifdef ERROR_LINK_STALE_EN
    else if (stale_hit) begin
      // A silent neighbour contributes zero error.
      error_d = '0;
    end
`endif
  end

  always_ff @(posedge fpga_clk_i or negedge reset_i) begin
    if (!reset_i) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      stop_q  <= 1'b0;
      error_q <= '0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      sync1_q <= serial_i;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      stop_q  <= stop_d;
      error_q <= error_d;
      valid_q <= valid_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
    end
  end

  assign error_o      = error_q;
  assign valid_o      = valid_q;
  assign parity_err_o = perr_q;
  assign frame_err_o  = ferr_q;

endmodule

// File: tb/tb_error_link_rx.sv
// Directed bench for error_link_rx; stale checks follow ERROR_LINK_STALE_EN when it is defined.
module tb_error_link_rx;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned BC    = 16;
  localparam int unsigned STALE = 256;
  localparam int          LAT   = 171;
`ifdef ERROR_LINK_STALE_EN
  localparam bit StaleEn = 1'b1;
`else
  localparam bit StaleEn = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             enable = 1'b1;
  logic             serial = 1'b1;
  logic [WIDTH-1:0] error_o;
  logic             valid_o, parity_err_o, frame_err_o, stale_o;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_valid = 0, n_perr = 0, n_ferr = 0, n_overlap = 0;
  int last_valid_cyc = -1;
  int fall_cyc = 0;
  int base_cyc = 0;
  int sv, sp, sf;
  int vcyc;

  error_link_rx #(
    .WIDTH       (WIDTH),
    .BIT_CYCLES  (BC),
    .STALE_CYCLES(STALE)
  ) dut (
    .fpga_clk_i  (clk),
    .reset_i     (rst_n),
    .enable_i    (enable),
    .serial_i    (serial),
    .error_o     (error_o),
    .valid_o     (valid_o),
    .parity_err_o(parity_err_o),
    .frame_err_o (frame_err_o),
    .stale_o     (stale_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid_o) begin
      n_valid++;
      last_valid_cyc = cyc;
    end
    if (parity_err_o) n_perr++;
    if (frame_err_o) n_ferr++;
    if (valid_o && (parity_err_o || frame_err_o)) n_overlap++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected stale state: counter restarts at reset release or at each good frame's valid cycle.
  function automatic logic exp_stale();
    return StaleEn && (cyc >= base_cyc + int'(STALE));
  endfunction

  function automatic logic [WIDTH-1:0] exp_err(input logic [WIDTH-1:0] v);
    return exp_stale() ? '0 : v;
  endfunction

  task automatic snap();
    sv = n_valid;
    sp = n_perr;
    sf = n_ferr;
  endtask

  task automatic check_deltas(input string tag, input int dv, input int dp, input int df);
    check({tag, "_valid"}, n_valid - sv, dv);
    check({tag, "_perr"}, n_perr - sp, dp);
    check({tag, "_ferr"}, n_ferr - sf, df);
  endtask

  task automatic drive_bit(input logic b);
    serial = b;
    repeat (BC) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [WIDTH-1:0] data, input logic par, input logic stop);
    fall_cyc = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < int'(WIDTH); i++) drive_bit(data[i]);
    drive_bit(par);
    drive_bit(stop);
    if (stop && (par == ^data)) base_cyc = fall_cyc + LAT;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  initial begin
    // Reset state
    idle(3);
    check("rst_error", error_o, 0);
    check("rst_valid", valid_o, 0);
    check("rst_perr", parity_err_o, 0);
    check("rst_ferr", frame_err_o, 0);
    check("rst_stale", stale_o, 0);
    rst_n = 1'b1;
    base_cyc = cyc;
    idle(5);

    // Good frame, latency, back-to-back frame
    snap();
    send_frame(8'hF6, 1'b0, 1'b1);
    check("f6_error", error_o, 8'hF6);
    check("f6_signed", int'($signed(error_o)), -10);
    check("f6_latency", last_valid_cyc - fall_cyc, LAT);
    check_deltas("f6", 1, 0, 0);
    snap();
    send_frame(8'h03, 1'b0, 1'b1);
    check("b2b_error", error_o, 8'h03);
    check_deltas("b2b", 1, 0, 0);

    // Parity error
    snap();
    send_frame(8'h05, 1'b1, 1'b1);
    check("par_error_held", error_o, exp_err(8'h03));
    check_deltas("par", 0, 1, 0);

    // Framing error, line held low, then recovery
    snap();
    send_frame(8'h10, 1'b1, 1'b0);
    idle(100);
    check_deltas("brk_low", 0, 0, 1);
    check("brk_error_held", error_o, exp_err(8'h03));
    serial = 1'b1;
    idle(20);
    check_deltas("brk_high", 0, 0, 1);
    snap();
    send_frame(8'h7F, 1'b1, 1'b1);
    check("after_brk_error", error_o, 8'h7F);
    check_deltas("after_brk", 1, 0, 0);

    // Short glitch on idle line
    snap();
    serial = 1'b0;
    idle(3);
    serial = 1'b1;
    idle(40);
    check_deltas("glitch", 0, 0, 0);

    // Disable mid-DATA drops the frame
    snap();
    drive_bit(1'b0);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    enable = 1'b0;
    drive_bit(1'b1);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    drive_bit(1'b1);
    idle(10);
    enable = 1'b1;
    idle(10);
    check_deltas("dis", 0, 0, 0);
    check("dis_error_held", error_o, exp_err(8'h7F));

    // Re-enable with the line already low must not start a frame
    snap();
    enable = 1'b0;
    serial = 1'b0;
    idle(30);
    enable = 1'b1;
    idle(30);
    serial = 1'b1;
    idle(200);
    check_deltas("reen_low", 0, 0, 0);
    snap();
    send_frame(8'hC3, 1'b0, 1'b1);
    check("after_dis_error", error_o, 8'hC3);
    check_deltas("after_dis", 1, 0, 0);

    // Asynchronous reset mid-frame
    drive_bit(1'b0);
    drive_bit(1'b0);
    drive_bit(1'b1);
    rst_n = 1'b0;
    #1;
    check("amid_error", error_o, 0);
    check("amid_valid", valid_o, 0);
    check("amid_perr", parity_err_o, 0);
    check("amid_ferr", frame_err_o, 0);
    check("amid_stale", stale_o, 0);
    serial = 1'b1;
    idle(3);
    rst_n = 1'b1;
    base_cyc = cyc;
    snap();
    idle(200);
    check_deltas("post_rst", 0, 0, 0);
    snap();
    send_frame(8'h81, 1'b0, 1'b1);
    check("post_rst_error", error_o, 8'h81);
    check_deltas("post_rst_frame", 1, 0, 0);

    // Silence after a good frame: stale (when built in) or held value
    send_frame(8'h20, 1'b1, 1'b1);
    check("s20_error", error_o, 8'h20);
    vcyc = fall_cyc + LAT;
    wait_until(vcyc + int'(STALE) - 1);
    check("pre_stale_error", error_o, exp_err(8'h20));
    check("pre_stale_flag", stale_o, exp_stale());
    @(negedge clk);
    check("stale_error", error_o, exp_err(8'h20));
    check("stale_flag", stale_o, exp_stale());
    wait_until(vcyc + int'(STALE) + 40);
    check("late_error", error_o, exp_err(8'h20));
    check("late_flag", stale_o, exp_stale());
    @(posedge clk);
    #1;
    snap();
    send_frame(8'hE0, 1'b1, 1'b1);
    check("e0_signed", int'($signed(error_o)), -32);
    check("e0_flag", stale_o, 0);
    check_deltas("e0", 1, 0, 0);

    check("no_overlap", n_overlap, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
